sha_msg_padder: RTL and testbench
=================================

Name: sha_msg_padder

Overview:
- Byte-stream front end for the SHA-256 engine; accepts a message one byte per cycle.
- Applies SHA-256 padding (0x80, zero fill, 64-bit big-endian bit length) and packs bytes big-endian into 16x32-bit blocks.
- Serves words to the engine indexed by the engine's free-running index.
- Drives last_word/last_next so the engine raises output_valid after the final block.

Parameters:
- CNT_W, 61, width of message byte counter; bit length = {count, 3'b000} zero-extended to 64 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  message byte.
- in_valid  input  1  in_data valid.
- in_last  input  1  qualifies the final message byte.
- in_ready  output  1  padder accepts a byte this cycle.
- eng_index  input  7  engine index (0..15 = word fetch, 127 = block start).
- word  output  32  combinational read of buffer word eng_index[3:0].
- last_word  output  1  block currently held/being fetched is the final padded block.
- last_next  output  2  {1'b0, last_word}.
- blk_ready  output  1  full 16-word block buffered, awaiting engine.
- underrun  output  1  sticky: engine reached index 0 with no ready block.
- done  output  1  final block handed over; stays high until rst.

Behaviour:
- Reset, synchronous: state=FILL, byte pointer=0, byte count=0, buffer=0. All outputs 0 except in_ready=1.
- Transfer: byte accepted when in_valid && in_ready. It is written at pointer, where byte k goes to word k/4 bits [31-8*(k%4) -: 8]. The pointer then increments.
- FSM states: FILL, PAD80, ZERO, LEN, FULL, DONE. in_ready=1 only in FILL.
- FILL:
  - accept bytes and increment count.
  - accepted byte with pointer==63 and !in_last -> FULL, final=0; refill continues in FILL after hand-off.
  - accepted byte with in_last -> PAD80; if pointer was 63, PAD80 waits for hand-off first.
- PAD80: write 0x80 at pointer (1 cycle) -> ZERO.
- ZERO: write 0x00 one per cycle until pointer==56 -> LEN. If 0x80 landed at pointer>=56, zero to 63 -> FULL with final=0, and after hand-off resume ZERO at pointer 0.
- LEN: write the 8 length bytes MSB first at 56..63 (8 cycles) -> FULL, final=1.
- FULL:
  - blk_ready=1; last_word=final.
  - Buffer is frozen while eng_index cycles 127,0..15.
  - Hand-off completes on the cycle eng_index==15. The next cycle resets the pointer to 0, clears blk_ready, and goes to FILL, ZERO or DONE (final).
  - last_word is held through index 65 of the final block. It stays asserted in DONE.
- DONE: in_ready=0, done=1. Further bytes are ignored until rst.
- Buffer is never written while eng_index in 0..15 and blk_ready=1.
- underrun: set when eng_index==0 and blk_ready==0 in any state except DONE. Cleared only by rst.
- Minimum message length is 1 byte; empty messages are unsupported.
- Timing: one block per 64 + engine-wait cycles at most; padding adds 1 cycle (0x80) + zero count + 8 cycles.
- rst mid-message: abandons all state; the engine must be reset together with the padder.
- in_last with in_valid=0 is ignored.

Decomposition:
- Package sha_pad_pkg:
  - state enum.
  - constants BLOCK_BYTES=64, LEN_POS=56, PAD_BYTE=8'h80, FETCH_LAST=15, IDX_START=127.
- Sub-module sha_block_buf: 64-byte register file, byte write port (addr 6b, data 8b, we) and combinational 32-bit word read port (addr 4b).

Test Plan:
- "abc" (0x61,0x62,0x63, in_last on 0x63) -> words 0x61626380, 0x00000000 x14, 0x00000018; last_word=1; engine hash ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- 55 bytes of 0x61 -> one block, word13=0x61616180, word15=0x000001B8, final on first block.
- 56 bytes of 0x61 -> block1 word14=0x80000000, word15=0 with last_word=0; block2 words 0..14=0, word15=0x000001C0 with last_word=1.
- 64 bytes -> block1 all data with last_word=0; block2 word0=0x80000000, word15=0x00000200 with last_word=1; in_ready=0 during FULL.
- Hold in_valid low until the engine wraps to index 0 -> underrun=1 and stays set; rst clears it along with all outputs.
- rst asserted mid-ZERO -> next cycle in_ready=1, blk_ready=0, done=0; a fresh "abc" gives the same result as the first scenario.

Source files
------------

// File: rtl/sha_pad_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha_pad_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned IDX_W       = 7;
  localparam int unsigned BLOCK_BYTES = 64;
  localparam int unsigned PTR_W       = $clog2(BLOCK_BYTES);

  localparam logic [PTR_W-1:0]  LEN_POS    = PTR_W'(56);
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(BLOCK_BYTES - 1);
  localparam logic [BYTE_W-1:0] PAD_BYTE   = 8'h80;
  localparam logic [IDX_W-1:0]  FETCH_LAST = 7'd15;
  localparam logic [IDX_W-1:0]  IDX_START  = 7'd127;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_PAD80,
    ST_ZERO,
    ST_LEN,
    ST_FULL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sha_block_buf.sv
// 64-byte block buffer: byte write port, big-endian 32-bit word read port.
module sha_block_buf
  import sha_pad_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic [3:0]        raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [BYTE_W-1:0] mem_q [BLOCK_BYTES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BLOCK_BYTES; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Byte 4*w is the most significant byte of word w.
  assign rdata_o = {mem_q[{raddr_i, 2'd0}], mem_q[{raddr_i, 2'd1}],
                    mem_q[{raddr_i, 2'd2}], mem_q[{raddr_i, 2'd3}]};

endmodule

// File: rtl/sha_msg_padder.sv
// SHA-256 byte-stream padder: packs message bytes, appends 0x80, zero fill and
// the 64-bit bit length, and serves 16-word blocks to the engine by index.
module sha_msg_padder
  import sha_pad_pkg::*;
#(
  parameter int unsigned CNT_W = 61
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data_i,
  input  logic              in_valid_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  input  logic [IDX_W-1:0]  eng_index_i,
  output logic [WORD_W-1:0] word_o,
  output logic              last_word_o,
  output logic [1:0]        last_next_o,
  output logic              blk_ready_o,
  output logic              underrun_o,
  output logic              done_o
);

  state_e            state_q;
  state_e            resume_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              in_ready_q;
  logic              blk_ready_q;
  logic              last_word_q;
  logic              underrun_q;
  logic              done_q;

  logic              wr_en_c;
  logic [BYTE_W-1:0] wr_data_c;
  logic [63:0]       bitlen_c;

  assign bitlen_c = 64'({cnt_q, 3'b000});

  // Byte written at the pointer this cycle; nothing is written while a block is held.
  always_comb begin
    wr_en_c   = 1'b0;
    wr_data_c = '0;
    unique case (state_q)
      ST_FILL: begin
        wr_en_c   = in_valid_i;
        wr_data_c = in_data_i;
      end
      ST_PAD80: begin
        wr_en_c   = 1'b1;
        wr_data_c = PAD_BYTE;
      end
      ST_ZERO: wr_en_c = 1'b1;
      ST_LEN: begin
        wr_en_c   = 1'b1;
        wr_data_c = BYTE_W'(bitlen_c >> {~ptr_q[2:0], 3'b000});
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      resume_q    <= ST_FILL;
      ptr_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      blk_ready_q <= 1'b0;
      last_word_q <= 1'b0;
      underrun_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (eng_index_i == '0 && !blk_ready_q && state_q != ST_DONE) underrun_q <= 1'b1;
      if (wr_en_c) ptr_q <= ptr_q + PTR_W'(1);

      unique case (state_q)
        ST_FILL: begin
          if (in_valid_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (ptr_q == PTR_LAST) begin
              state_q     <= ST_FULL;
              resume_q    <= in_last_i ? ST_PAD80 : ST_FILL;
              in_ready_q  <= 1'b0;
              blk_ready_q <= 1'b1;
            end else if (in_last_i) begin
              state_q    <= ST_PAD80;
              in_ready_q <= 1'b0;
            end
          end
        end
        ST_PAD80, ST_ZERO: begin
          if (ptr_q == LEN_POS - PTR_W'(1)) begin
            state_q <= ST_LEN;
          end else if (ptr_q == PTR_LAST) begin
            // Marker spilled past the length slot: ship this block, zero-fill the next.
            state_q     <= ST_FULL;
            resume_q    <= ST_ZERO;
            blk_ready_q <= 1'b1;
          end else begin
            state_q <= ST_ZERO;
          end
        end
        ST_LEN: begin
          if (ptr_q == PTR_LAST) begin
            state_q     <= ST_FULL;
            resume_q    <= ST_DONE;
            blk_ready_q <= 1'b1;
            last_word_q <= 1'b1;
          end
        end
        ST_FULL: begin
          if (eng_index_i == FETCH_LAST) begin
            state_q     <= resume_q;
            ptr_q       <= '0;
            blk_ready_q <= 1'b0;
            in_ready_q  <= (resume_q == ST_FILL);
            done_q      <= (resume_q == ST_DONE);
          end
        end
        default: ;
      endcase
    end
  end

  sha_block_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_en_c),
    .waddr_i (ptr_q),
    .wdata_i (wr_data_c),
    .raddr_i (eng_index_i[3:0]),
    .rdata_o (word_o)
  );

  assign in_ready_o  = in_ready_q;
  assign blk_ready_o = blk_ready_q;
  assign last_word_o = last_word_q;
  assign last_next_o = {1'b0, last_word_q};
  assign underrun_o  = underrun_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_sha_msg_padder.sv
// Bench for sha_msg_padder: table vectors, corner sequences and random messages
// checked against a queue-based SHA-256 padding model.
`timescale 1ns/1ps
module tb_sha_msg_padder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready_o;
  logic [6:0]  idx;
  logic [31:0] word_o;
  logic        last_word_o;
  logic [1:0]  last_next_o;
  logic        blk_ready_o;
  logic        underrun_o;
  logic        done_o;

  bit free_run = 1'b0;
  int n_vec = 0;
  int n_err = 0;

  logic [7:0]         msg[$];
  logic [15:0][31:0]  exp_blk[$];
  logic [15:0][31:0]  cap_blk[$];
  logic               cap_last[$];
  logic               cap_inr[$];

  typedef struct {
    int          len;
    logic [7:0]  base;
    logic [7:0]  step;
    int          nblk;
    logic [31:0] w0;
    logic [31:0] w14;
    logic [31:0] w15;
  } vec_t;

  vec_t tbl[5];

  always #5 clk = ~clk;

  sha_msg_padder dut (
    .clk         (clk),
    .rst         (rst),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_last_i   (in_last),
    .in_ready_o  (in_ready_o),
    .eng_index_i (idx),
    .word_o      (word_o),
    .last_word_o (last_word_o),
    .last_next_o (last_next_o),
    .blk_ready_o (blk_ready_o),
    .underrun_o  (underrun_o),
    .done_o      (done_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Engine model: idles at 127, starts a pass when a block is ready, runs 0..67.
  initial begin
    idx = 7'd127;
    forever begin
      @(posedge clk); #2;
      if (rst)                  idx = 7'd127;
      else if (idx == 7'd127)   idx = (free_run || blk_ready_o) ? 7'd0 : 7'd127;
      else if (idx == 7'd67)    idx = 7'd127;
      else                      idx = idx + 7'd1;
    end
  end

  // Collects each fetched block together with last_word and in_ready at index 15.
  initial begin
    logic [15:0][31:0] cur;
    cur = '0;
    forever begin
      @(negedge clk);
      if (!rst && blk_ready_o && idx <= 7'd15) begin
        cur[idx[3:0]] = word_o;
        if (idx == 7'd15) begin
          cap_blk.push_back(cur);
          cap_last.push_back(last_word_o);
          cap_inr.push_back(in_ready_o);
        end
      end
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_capture();
    cap_blk.delete();
    cap_last.delete();
    cap_inr.delete();
  endtask

  task automatic do_rst();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_capture();
  endtask

  // Padding model: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit count.
  task automatic build_model();
    logic [7:0]        p[$];
    logic [63:0]       bl;
    logic [15:0][31:0] blk;
    p  = msg;
    bl = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    exp_blk.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int w = 0; w < 16; w++)
        blk[w] = {p[b*64+4*w], p[b*64+4*w+1], p[b*64+4*w+2], p[b*64+4*w+3]};
      exp_blk.push_back(blk);
    end
  endtask

  task automatic feed(input bit gaps);
    int  k;
    int  stall;
    bit  v;
    bit  ok;
    k = 0; stall = 0;
    while (k < msg.size()) begin
      v        = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid = v;
      in_data  = v ? msg[k] : 8'($urandom);
      in_last  = v ? (k == msg.size() - 1) : 1'($urandom_range(0, 1));
      ok       = v && in_ready_o;
      @(posedge clk); #1;
      if (ok) begin
        k++; stall = 0;
      end else if (++stall > 300) begin
        check("feed_stall", 64'(k), 64'(msg.size()));
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_msg(input bit do_reset, input bit gaps, input string tag);
    int c;
    if (do_reset) do_rst();
    build_model();
    feed(gaps);
    c = 0;
    while (!done_o && c < 5000) begin
      @(posedge clk); #1;
      c++;
    end
    check({tag, "_done"}, 64'(done_o), 64'd1);
    check({tag, "_nblk"}, 64'(cap_blk.size()), 64'(exp_blk.size()));
    for (int b = 0; b < cap_blk.size() && b < exp_blk.size(); b++) begin
      for (int w = 0; w < 16; w++)
        check($sformatf("%s_b%0d_w%0d", tag, b, w), 64'(cap_blk[b][w]), 64'(exp_blk[b][w]));
      check($sformatf("%s_b%0d_last", tag, b), 64'(cap_last[b]), 64'(b == exp_blk.size() - 1));
      check($sformatf("%s_b%0d_inready", tag, b), 64'(cap_inr[b]), 64'd0);
    end
    check({tag, "_last_next"}, 64'(last_next_o), 64'd1);
    check({tag, "_inready_done"}, 64'(in_ready_o), 64'd0);
    check({tag, "_underrun"}, 64'(underrun_o), 64'd0);
  endtask

  task automatic check_tbl_last(input int i);
    logic [15:0][31:0] lb;
    check($sformatf("tbl%0d_nblk", i), 64'(cap_blk.size()), 64'(tbl[i].nblk));
    if (cap_blk.size() > 0) begin
      lb = cap_blk[cap_blk.size() - 1];
      check($sformatf("tbl%0d_w0", i),  64'(lb[0]),  64'(tbl[i].w0));
      check($sformatf("tbl%0d_w14", i), 64'(lb[14]), 64'(tbl[i].w14));
      check($sformatf("tbl%0d_w15", i), 64'(lb[15]), 64'(tbl[i].w15));
    end
  endtask

  task automatic set_tbl_msg(input int i);
    msg.delete();
    for (int k = 0; k < tbl[i].len; k++)
      msg.push_back(8'(int'(tbl[i].base) + k * int'(tbl[i].step)));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;

    tbl[0] = '{len: 3,  base: 8'h61, step: 8'h01, nblk: 1, w0: 32'h61626380, w14: 32'h0, w15: 32'h00000018};
    tbl[1] = '{len: 55, base: 8'h61, step: 8'h00, nblk: 1, w0: 32'h61616161, w14: 32'h0, w15: 32'h000001B8};
    tbl[2] = '{len: 56, base: 8'h61, step: 8'h00, nblk: 2, w0: 32'h00000000, w14: 32'h0, w15: 32'h000001C0};
    tbl[3] = '{len: 64, base: 8'h61, step: 8'h00, nblk: 2, w0: 32'h80000000, w14: 32'h0, w15: 32'h00000200};
    tbl[4] = '{len: 1,  base: 8'h5A, step: 8'h00, nblk: 1, w0: 32'h5A800000, w14: 32'h0, w15: 32'h00000008};

    do_rst();
    check("rst_in_ready",  64'(in_ready_o),  64'd1);
    check("rst_blk_ready", 64'(blk_ready_o), 64'd0);
    check("rst_last_word", 64'(last_word_o), 64'd0);
    check("rst_last_next", 64'(last_next_o), 64'd0);
    check("rst_underrun",  64'(underrun_o),  64'd0);
    check("rst_done",      64'(done_o),      64'd0);
    check("rst_word",      64'(word_o),      64'd0);

    for (int i = 0; i < 5; i++) begin
      set_tbl_msg(i);
      run_msg(1'b1, 1'b0, $sformatf("tbl%0d", i));
      check_tbl_last(i);
    end

    // 56-byte message: marker lands in the length slot, first block is not final.
    set_tbl_msg(2);
    run_msg(1'b1, 1'b0, "m56");
    if (cap_blk.size() == 2) begin
      check("m56_b0_w14", 64'(cap_blk[0][14]), 64'h80000000);
      check("m56_b0_w15", 64'(cap_blk[0][15]), 64'h0);
      check("m56_b0_last", 64'(cap_last[0]), 64'd0);
    end

    // Engine wraps with no block ready: underrun is sticky until rst.
    do_rst();
    free_run = 1'b1;
    for (int c = 0; c < 200 && !underrun_o; c++) begin
      @(posedge clk); #1;
    end
    check("underrun_set", 64'(underrun_o), 64'd1);
    repeat (150) @(posedge clk);
    #1;
    check("underrun_sticky", 64'(underrun_o), 64'd1);
    check("underrun_inready", 64'(in_ready_o), 64'd1);
    free_run = 1'b0;
    do_rst();
    check("underrun_clr", 64'(underrun_o), 64'd0);
    check("underrun_clr_inready", 64'(in_ready_o), 64'd1);

    // Reset in the middle of zero fill, then a fresh "abc".
    set_tbl_msg(0);
    do_rst();
    feed(1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("midzero_busy", 64'(in_ready_o), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_capture();
    check("midzero_in_ready",  64'(in_ready_o),  64'd1);
    check("midzero_blk_ready", 64'(blk_ready_o), 64'd0);
    check("midzero_done",      64'(done_o),      64'd0);
    run_msg(1'b0, 1'b0, "abc2");
    check_tbl_last(0);

    // Bytes offered after completion are ignored.
    in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    check("done_hold", 64'(done_o), 64'd1);
    check("done_blk_ready", 64'(blk_ready_o), 64'd0);

    for (int r = 0; r < 20; r++) begin
      int len;
      len = $urandom_range(1, 150);
      msg.delete();
      for (int k = 0; k < len; k++) msg.push_back(8'($urandom));
      run_msg(1'b1, 1'b1, $sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
